// File: rtl/total_exponent_split.sv
// Splits a signed total exponent into clamped regime k, ES exponent bits and regime run length.
// Build option PIPE_REG2_EN: registered clamp stage (latency 2); undefined gives latency 1.
module total_exponent_split #(
  parameter int N        = 16,
  parameter int ES       = 1,
  parameter int K_BITS   = $clog2(N) + 1,
  parameter int TE_BITS  = K_BITS + ES + 2,
  parameter int LEN_BITS = $clog2(N) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [TE_BITS-1:0]  total_exp_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [K_BITS-1:0]   k_o,
  output logic [ES-1:0]       exp_o,
  output logic [LEN_BITS-1:0] reg_len_o,
  output logic                sat_o
);

  localparam logic signed [TE_BITS-1:0] K_HI    = TE_BITS'(N - 2);
  localparam logic signed [TE_BITS-1:0] K_LO    = -K_HI;
  localparam logic signed [K_BITS-1:0]  K_SAT   = K_BITS'(N - 2);
  localparam logic [LEN_BITS-1:0]       LEN_MAX = LEN_BITS'(N - 1);

  logic                       s1_full;
  logic signed [TE_BITS-1:0]  s1_k;
  logic [ES-1:0]              s1_e;
  logic                       accept_in;

  logic signed [K_BITS-1:0]   k_c;
  logic [ES-1:0]              e_c;
  logic [LEN_BITS-1:0]        len_c;
  logic                       sat_c;

  assign accept_in = valid_i && ready_o;

  // k_raw is kept at full total-exponent width so huge magnitudes cannot wrap into range.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_k <= '0;
      s1_e <= '0;
    end else if (accept_in) begin
      s1_k <= $signed(total_exp_i) >>> ES;
      s1_e <= total_exp_i[ES-1:0];
    end
  end

  always_comb begin
    k_c   = s1_k[K_BITS-1:0];
    e_c   = s1_e;
    sat_c = 1'b0;
    if (s1_k > K_HI) begin
      k_c   = K_SAT;
      e_c   = '1;
      sat_c = 1'b1;
    end else if (s1_k < K_LO) begin
      k_c   = -K_SAT;
      e_c   = '0;
      sat_c = 1'b1;
    end
    len_c = k_c[K_BITS-1] ? LEN_BITS'(-k_c) + LEN_BITS'(1) : LEN_BITS'(k_c) + LEN_BITS'(2);
    // At the regime extremes the terminator bit falls off the end of the posit.
    if (len_c > LEN_MAX) len_c = LEN_MAX;
  end

`ifdef PIPE_REG2_EN
  logic s2_full;
  logic s2_load;

  assign s2_load = s1_full && (!s2_full || ready_i);
  assign ready_o = !s1_full || s2_load;
  assign valid_o = s2_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
    end else begin
      if (accept_in)    s1_full <= 1'b1;
      else if (s2_load) s1_full <= 1'b0;
      if (s2_load)      s2_full <= 1'b1;
      else if (ready_i) s2_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_o       <= '0;
      exp_o     <= '0;
      reg_len_o <= '0;
      sat_o     <= 1'b0;
    end else if (s2_load) begin
      k_o       <= k_c;
      exp_o     <= e_c;
      reg_len_o <= len_c;
      sat_o     <= sat_c;
    end
  end
`else
  logic loaded;

  assign ready_o = !s1_full || ready_i;
  assign valid_o = s1_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_full <= 1'b0;
      loaded  <= 1'b0;
    end else begin
      if (accept_in)    s1_full <= 1'b1;
      else if (ready_i) s1_full <= 1'b0;
      if (accept_in)    loaded  <= 1'b1;
    end
  end

  // Until the first capture the fields read as zero rather than the decode of the reset register.
  always_comb begin
    k_o       = '0;
    exp_o     = '0;
    reg_len_o = '0;
    sat_o     = 1'b0;
    if (loaded) begin
      k_o       = k_c;
      exp_o     = e_c;
      reg_len_o = len_c;
      sat_o     = sat_c;
    end
  end
`endif

endmodule
